// File: rtl/sm_clk_ctrl.sv
// Core-clock controller: programmable divider with run/halt/step, PC breakpoint and core-cycle counter.
// clkOut/clkTick registered on clkIn; rises are only ever withheld, so clkOut always stops low.
module sm_clk_ctrl #(
  parameter int DIV_W     = 4,
  parameter int CNT_W     = 32,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clkDevide,
  input  logic             clkEnable,
  input  logic             haltReq,
  input  logic             runReq,
  input  logic             stepReq,
  input  logic             bpEnable,
  input  logic [31:0]      bpAddr,
  input  logic [31:0]      pc,
  output logic             clkOut,
  output logic             clkTick,
  output logic             halted,
  output logic [CNT_W-1:0] cycleCount
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam state_t RST_STATE = RESET_RUN ? RUN : HALT;

  state_t           state, stateNext;
  logic [DIV_W-1:0] cnt, cntNext;
  logic             skipBp, skipBpNext;
  logic             togglePoint, risePoint, fallTaken, riseTaken;
  logic             bpHit, gateOpen;

  assign togglePoint = (cnt >= clkDevide);
  assign risePoint   = togglePoint && !clkOut;
  assign fallTaken   = togglePoint && clkOut;
  assign bpHit       = risePoint && bpEnable && (pc == bpAddr) && !skipBp;

  // haltReq wins over everything, so it also withholds a rise due on the same edge
  assign gateOpen  = clkEnable && !haltReq &&
                     (((state == RUN) && !bpHit) || (state == STEP));
  assign riseTaken = risePoint && gateOpen;

  assign halted = (state == HALT) && !clkOut;

  always_comb begin
    stateNext  = state;
    skipBpNext = skipBp;
    if (riseTaken) skipBpNext = 1'b0;
    case (state)
      RUN: begin
        if (haltReq || bpHit) stateNext = HALT;
      end
      HALT: begin
        if (haltReq) begin
          stateNext = HALT;
        end else if (runReq) begin
          stateNext  = RUN;
          skipBpNext = 1'b1;
        end else if (stepReq) begin
          stateNext  = STEP;
          skipBpNext = 1'b1;
        end
      end
      STEP: begin
        if (haltReq || riseTaken) stateNext = HALT;
      end
      default: stateNext = HALT;
    endcase
  end

  // A blocked rise parks cnt at the toggle point so the rise fires as soon as the gate opens
  always_comb begin
    cntNext = cnt + DIV_W'(1);
    if (fallTaken || riseTaken) cntNext = '0;
    else if (togglePoint)       cntNext = cnt;
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cnt        <= '0;
      skipBp     <= 1'b0;
      clkOut     <= 1'b0;
      clkTick    <= 1'b0;
      cycleCount <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      skipBp  <= skipBpNext;
      clkOut  <= clkOut ? !fallTaken : riseTaken;
      clkTick <= riseTaken;
      if (riseTaken) cycleCount <= cycleCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed bench for sm_clk_ctrl; a second instance (CNT_W=4, starts halted) covers counter wrap.
module tb_sm_clk_ctrl;

  logic        clkIn = 1'b0;
  logic        rst_n, rst2_n;
  logic [3:0]  clkDevide, clkDevide2;
  logic        clkEnable, haltReq, runReq, stepReq, bpEnable;
  logic        clkEnable2, runReq2;
  logic [31:0] bpAddr, pc;
  logic        clkOut, clkTick, halted;
  logic [31:0] cycleCount;
  logic        clkOut2, clkTick2, halted2;
  logic [3:0]  cycleCount2;

  int testCnt = 0;
  int failCnt = 0;
  int riseCnt = 0;
  int highCnt = 0;
  int tickErr = 0;
  int n2;
  logic prevOut = 1'b0;
  logic pcAuto  = 1'b0;

  always #5 clkIn = ~clkIn;

  sm_clk_ctrl #(.DIV_W(4), .CNT_W(32), .RESET_RUN(1'b1)) dut (
    .clkIn(clkIn), .rst_n(rst_n), .clkDevide(clkDevide), .clkEnable(clkEnable),
    .haltReq(haltReq), .runReq(runReq), .stepReq(stepReq), .bpEnable(bpEnable),
    .bpAddr(bpAddr), .pc(pc), .clkOut(clkOut), .clkTick(clkTick), .halted(halted),
    .cycleCount(cycleCount)
  );

  sm_clk_ctrl #(.DIV_W(4), .CNT_W(4), .RESET_RUN(1'b0)) dut2 (
    .clkIn(clkIn), .rst_n(rst2_n), .clkDevide(clkDevide2), .clkEnable(clkEnable2),
    .haltReq(1'b0), .runReq(runReq2), .stepReq(1'b0), .bpEnable(1'b0),
    .bpAddr(32'h0), .pc(32'h0), .clkOut(clkOut2), .clkTick(clkTick2), .halted(halted2),
    .cycleCount(cycleCount2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each cycle models the core: pc advances on every clkOut rise when pcAuto is set
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkIn);
      #1;
      if (clkTick) riseCnt++;
      if (clkOut) highCnt++;
      if (clkTick !== (clkOut && !prevOut)) tickErr++;
      prevOut = clkOut;
      if (pcAuto && clkTick) pc = (pc + 32'd4) & 32'h1F;
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    clkDevide = 4'd0; clkEnable = 1'b1;
    haltReq = 1'b0; runReq = 1'b0; stepReq = 1'b0;
    bpEnable = 1'b0; bpAddr = 32'h10; pc = 32'h0;
    clkDevide2 = 4'd0; clkEnable2 = 1'b1; runReq2 = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
    chk("rst_clkOut", {31'b0, clkOut}, 0);
    chk("rst_clkTick", {31'b0, clkTick}, 0);
    chk("rst_cycleCount", cycleCount, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    rst_n = 1'b1;

    // D=0: first rise on edge 1, period 2
    cyc(1);
    chk("d0_first_rise", {31'b0, clkOut}, 1);
    chk("d0_first_tick", {31'b0, clkTick}, 1);
    riseCnt = 0; highCnt = 0;
    cyc(19);
    chk("d0_rises", riseCnt, 9);
    chk("d0_highs", highCnt, 9);
    chk("d0_count10", cycleCount, 10);

    // D=3: period 8, first rise 4 edges after the last fall
    clkDevide = 4'd3;
    riseCnt = 0; highCnt = 0;
    cyc(80);
    chk("d3_rises", riseCnt, 10);
    chk("d3_highs", highCnt, 40);
    chk("d3_count", cycleCount, 20);

    cyc(4);
    chk("pre_halt_rise", {31'b0, clkTick}, 1);
    haltReq = 1'b1;
    cyc(1);
    haltReq = 1'b0;
    chk("halt_still_high", {31'b0, clkOut}, 1);
    chk("halt_not_halted", {31'b0, halted}, 0);
    cyc(2);
    chk("halt_high_full", {31'b0, clkOut}, 1);
    cyc(1);
    chk("halt_fall", {31'b0, clkOut}, 0);
    chk("halt_halted", {31'b0, halted}, 1);
    riseCnt = 0;
    cyc(30);
    chk("halt_no_rise", riseCnt, 0);
    chk("halt_frozen", cycleCount, 21);

    riseCnt = 0;
    for (int s = 0; s < 3; s++) begin
      stepReq = 1'b1;
      cyc(1);
      stepReq = 1'b0;
      cyc(1);
      chk("step_tick", {31'b0, clkTick}, 1);
      cyc(18);
      chk("step_halted", {31'b0, halted}, 1);
    end
    chk("step_rises", riseCnt, 3);
    chk("step_count", cycleCount, 24);

    // Breakpoint at 0x10 with pc wrapping every 8 instructions
    bpEnable = 1'b1; bpAddr = 32'h10; pc = 32'h0; pcAuto = 1'b1;
    riseCnt = 0;
    runReq = 1'b1;
    cyc(1);
    runReq = 1'b0;
    cyc(59);
    chk("bp_rises", riseCnt, 4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_halted", {31'b0, halted}, 1);
    chk("bp_count", cycleCount, 28);

    riseCnt = 0;
    runReq = 1'b1;
    cyc(1);
    runReq = 1'b0;
    cyc(99);
    chk("bp2_rises", riseCnt, 8);
    chk("bp2_pc", pc, 32'h10);
    chk("bp2_halted", {31'b0, halted}, 1);
    chk("bp2_count", cycleCount, 36);

    pcAuto = 1'b0; bpEnable = 1'b0;
    runReq = 1'b1;
    cyc(1);
    runReq = 1'b0;
    cyc(10);
    haltReq = 1'b1; runReq = 1'b1; stepReq = 1'b1;
    cyc(1);
    haltReq = 1'b0; runReq = 1'b0; stepReq = 1'b0;
    riseCnt = 0;
    cyc(20);
    chk("prio_no_rise", riseCnt, 0);
    chk("prio_halted", {31'b0, halted}, 1);

    clkEnable = 1'b0;
    runReq = 1'b1;
    cyc(1);
    runReq = 1'b0;
    riseCnt = 0;
    cyc(40);
    chk("gate_no_rise", riseCnt, 0);
    chk("gate_run", {31'b0, halted}, 0);
    chk("gate_count", cycleCount, 38);
    clkEnable = 1'b1;
    cyc(1);
    chk("gate_open_tick", {31'b0, clkTick}, 1);
    chk("gate_open_count", cycleCount, 39);

    #1 rst_n = 1'b0;
    #1;
    chk("arst_clkOut", {31'b0, clkOut}, 0);
    chk("arst_clkTick", {31'b0, clkTick}, 0);
    chk("arst_count", cycleCount, 0);
    chk("arst_state_run", {31'b0, halted}, 0);
    chk("tick_consistency", tickErr, 0);

    rst2_n = 1'b1;
    cyc(5);
    chk("w_reset_halted", {31'b0, halted2}, 1);
    chk("w_reset_count", {28'b0, cycleCount2}, 0);
    runReq2 = 1'b1;
    cyc(1);
    runReq2 = 1'b0;
    n2 = 0;
    for (int i = 0; i < 100 && n2 < 17; i++) begin
      cyc(1);
      if (clkTick2) n2++;
    end
    chk("w_rises", n2, 17);
    chk("w_wrap", {28'b0, cycleCount2}, 1);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
